// File: rtl/dsi_hs_multilane_tx.sv
// Multi-lane DSI HS transmit sequencer: HS-GO zeros, SYNC byte, payload, per-lane HS-TRAIL.
// Latency: lane outputs lag the sequencer state by one cycle; data_rqst is aligned with ACTIVE.
// Backpressure: none; the byte source must present a word in every cycle data_rqst is high.
module dsi_hs_multilane_tx #(
    parameter int         LANES     = 4,
    parameter int         CNT_W     = 8,
    parameter logic [7:0] SYNC_BYTE = 8'h1D
) (
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic                 start_rqst,
    input  logic                 fin_rqst,
    input  logic [8*LANES-1:0]   inp_data,
    input  logic [LANES-1:0]     inp_last_mask,
    input  logic [2:0]           cfg_lanes,
    input  logic [CNT_W-1:0]     cfg_go_cycles,
    input  logic [CNT_W-1:0]     cfg_trail_cycles,
    output logic                 data_rqst,
    output logic                 active,
    output logic                 fin_ack,
    output logic [8*LANES-1:0]   lane_data,
    output logic [LANES-1:0]     lane_oe
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GO     = 3'd1;
    localparam logic [2:0] S_SYNC   = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_TRAIL  = 3'd4;

    localparam logic [2:0] MAX_N = 3'(LANES);

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       go_cnt_q, go_cnt_d;
    logic [CNT_W-1:0]       trail_cnt_q, trail_cnt_d;
    logic [CNT_W-1:0]       trail_len_q, trail_len_d;
    logic [2:0]             n_q, n_d;
    logic [LANES-1:0][7:0]  trail_byte_q, trail_byte_d;
    logic [8*LANES-1:0]     lane_data_q, lane_data_d;
    logic [LANES-1:0]       lane_oe_q, lane_oe_d;
    logic                   data_rqst_q, data_rqst_d;
    logic                   active_q, active_d;
    logic                   fin_ack_q, fin_ack_d;
    logic [2:0]             n_clamp;
    logic [LANES-1:0]       eff_mask;

    assign n_clamp  = (cfg_lanes == 3'd0) ? 3'd1 : ((cfg_lanes > MAX_N) ? MAX_N : cfg_lanes);
    // Lane 0 always carries the final word, so its mask bit is forced on.
    assign eff_mask = inp_last_mask | LANES'(1);

    // Sequencer next state, counters and burst configuration latch.
    always_comb begin
        state_d     = state_q;
        go_cnt_d    = go_cnt_q;
        trail_cnt_d = trail_cnt_q;
        trail_len_d = trail_len_q;
        n_d         = n_q;
        case (state_q)
            S_IDLE: begin
                if (start_rqst) begin
                    state_d     = S_GO;
                    go_cnt_d    = cfg_go_cycles;
                    trail_len_d = cfg_trail_cycles;
                    n_d         = n_clamp;
                end
            end
            S_GO: begin
                if (go_cnt_q == '0) state_d = S_SYNC;
                else                go_cnt_d = go_cnt_q - 1'b1;
            end
            S_SYNC:   state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (fin_rqst) begin
                    state_d     = S_TRAIL;
                    trail_cnt_d = trail_len_q;
                end
            end
            S_TRAIL: begin
                if (trail_cnt_q == '0) state_d = S_IDLE;
                else                   trail_cnt_d = trail_cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-lane output register and trail byte tracking, driven from the current state.
    always_comb begin
        lane_oe_d    = '0;
        lane_data_d  = '0;
        trail_byte_d = trail_byte_q;
        for (int k = 0; k < LANES; k++) begin
            if (3'(k) < n_q) begin
                case (state_q)
                    S_GO: lane_oe_d[k] = 1'b1;
                    S_SYNC: begin
                        lane_oe_d[k]         = 1'b1;
                        lane_data_d[8*k +: 8] = SYNC_BYTE;
                    end
                    S_ACTIVE: begin
                        lane_oe_d[k] = 1'b1;
                        if (!fin_rqst || eff_mask[k]) begin
                            lane_data_d[8*k +: 8] = inp_data[8*k +: 8];
                            trail_byte_d[k]       = {8{~inp_data[8*k+7]}};
                        end else begin
                            // Lane has no byte in the final word: start trailing now.
                            lane_data_d[8*k +: 8] = trail_byte_q[k];
                        end
                    end
                    S_TRAIL: begin
                        lane_oe_d[k]          = 1'b1;
                        lane_data_d[8*k +: 8] = trail_byte_q[k];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Handshake outputs; active and fin_ack follow the lane output timing.
    always_comb begin
        data_rqst_d = (state_d == S_ACTIVE);
        active_d    = (state_q != S_IDLE);
        fin_ack_d   = (state_q == S_IDLE) && active_q;
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            go_cnt_q     <= '0;
            trail_cnt_q  <= '0;
            trail_len_q  <= '0;
            n_q          <= '0;
            trail_byte_q <= '0;
            lane_data_q  <= '0;
            lane_oe_q    <= '0;
            data_rqst_q  <= 1'b0;
            active_q     <= 1'b0;
            fin_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_cnt_q     <= go_cnt_d;
            trail_cnt_q  <= trail_cnt_d;
            trail_len_q  <= trail_len_d;
            n_q          <= n_d;
            trail_byte_q <= trail_byte_d;
            lane_data_q  <= lane_data_d;
            lane_oe_q    <= lane_oe_d;
            data_rqst_q  <= data_rqst_d;
            active_q     <= active_d;
            fin_ack_q    <= fin_ack_d;
        end
    end

    assign data_rqst = data_rqst_q;
    assign active    = active_q;
    assign fin_ack   = fin_ack_q;
    assign lane_data = lane_data_q;
    assign lane_oe   = lane_oe_q;

endmodule

// File: tb/tb_dsi_hs_multilane_tx.sv
// Bench for dsi_hs_multilane_tx: table rows plus random bursts against a burst-level model.
// Latency: expected lane frames are laid out by burst phase, one frame per cycle.
// Backpressure: the bench supplies a word in every data_rqst cycle.
module tb_dsi_hs_multilane_tx;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        start_rqst, fin_rqst;
    logic [31:0] inp_data;
    logic [3:0]  inp_last_mask;
    logic [2:0]  cfg_lanes;
    logic [7:0]  cfg_go_cycles, cfg_trail_cycles;
    logic        data_rqst, active, fin_ack;
    logic [31:0] lane_data;
    logic [3:0]  lane_oe;

    int errors = 0;
    int checks = 0;

    logic [3:0][31:0] words;
    logic [7:0]       mtrail [4];

    dsi_hs_multilane_tx #(.LANES(4), .CNT_W(8), .SYNC_BYTE(8'h1D)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .start_rqst(start_rqst), .fin_rqst(fin_rqst),
        .inp_data(inp_data), .inp_last_mask(inp_last_mask), .cfg_lanes(cfg_lanes),
        .cfg_go_cycles(cfg_go_cycles), .cfg_trail_cycles(cfg_trail_cycles),
        .data_rqst(data_rqst), .active(active), .fin_ack(fin_ack),
        .lane_data(lane_data), .lane_oe(lane_oe)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {25'd0, data_rqst, active, fin_ack, lane_oe, lane_data};
    endfunction

    function automatic logic [63:0] frame(input logic rq, input logic act, input logic fa,
                                          input logic [3:0] oe, input logic [31:0] d);
        return {25'd0, rq, act, fa, oe, d};
    endfunction

    // One burst, beginning at the edge that samples start_rqst (E0). words[] holds the payload.
    task automatic run_burst(input int lanes_cfg, input int go, input int tr, input int nw,
                             input logic [3:0] mask, input bit spur, input bit chained,
                             input bit hold_next, input int nl, input int ngo, input int ntr,
                             output logic [31:0] trail_seen, output int rq_cnt);
        int n, total, last_j, f, w;
        logic [3:0]  eoe;
        logic [31:0] ed;
        logic [7:0]  b;
        logic [3:0]  em;
        logic        erq;
        n = (lanes_cfg == 0) ? 1 : ((lanes_cfg > 4) ? 4 : lanes_cfg);
        total = go + nw + tr + 3;
        last_j = hold_next ? total : total + 1;
        trail_seen = '0;
        rq_cnt = 0;
        em = mask | 4'b0001;
        if (!chained) begin
            cfg_lanes        = 3'(lanes_cfg);
            cfg_go_cycles    = 8'(go);
            cfg_trail_cycles = 8'(tr);
            start_rqst       = 1'b1;
        end
        for (int j = 0; j <= last_j; j++) begin
            @(posedge clk_sys); #1;
            erq = (j >= go + 2) && (j <= go + 1 + nw);
            if (data_rqst) rq_cnt++;
            if (j == 0) begin
                chk("lead", j, outs(), frame(erq, 1'b0, chained, 4'h0, 32'h0));
            end else if (j == total + 1) begin
                chk("finack", j, outs(), frame(erq, 1'b0, 1'b1, 4'h0, 32'h0));
            end else begin
                f = j - 1;
                eoe = '0;
                ed  = '0;
                for (int k = 0; k < n; k++) begin
                    eoe[k] = 1'b1;
                    if (f == go + 1) begin
                        ed[8*k +: 8] = 8'h1D;
                    end else if (f > go + 1 && f <= go + 1 + nw) begin
                        w = f - go - 2;
                        if (w != nw - 1 || em[k]) begin
                            b = words[w][8*k +: 8];
                            ed[8*k +: 8] = b;
                            mtrail[k] = b[7] ? 8'h00 : 8'hFF;
                        end else begin
                            ed[8*k +: 8] = mtrail[k];
                        end
                    end else if (f > go + 1 + nw) begin
                        ed[8*k +: 8] = mtrail[k];
                    end
                end
                chk("frame", j, outs(), frame(erq, 1'b1, 1'b0, eoe, ed));
                if (f == go + nw + 2) trail_seen = lane_data;
            end
            // Inputs for the next edge.
            if (j == 0) begin
                cfg_lanes        = hold_next ? 3'(nl) : 3'($urandom_range(7));
                cfg_go_cycles    = hold_next ? 8'(ngo) : 8'($urandom_range(255));
                cfg_trail_cycles = hold_next ? 8'(ntr) : 8'($urandom_range(255));
            end
            start_rqst = (spur && j == go + 3) || (hold_next && j == total);
            if (j >= go + 2 && j <= go + 1 + nw) begin
                inp_data      = words[j - go - 2];
                fin_rqst      = (j == go + 1 + nw);
                inp_last_mask = fin_rqst ? mask : 4'($urandom_range(15));
            end else begin
                inp_data      = $urandom;
                inp_last_mask = 4'($urandom_range(15));
                fin_rqst      = spur && j == 1;
            end
        end
        fin_rqst = 1'b0;
    endtask

    typedef struct {
        int               lanes, go, tr, nw;
        logic [3:0][31:0] w;
        logic [3:0]       mask;
        bit               spur, hold;
        logic [31:0]      exp_trail;
    } vec_t;

    vec_t        tbl [7];
    logic [31:0] tseen;
    int          rq;
    bit          chained;

    initial begin
        tbl[0] = '{1, 3, 2, 3, {32'h0, 32'h123456A5, 32'hCAFE0022, 32'hDEADBE11}, 4'b0000, 1'b0, 1'b0, 32'h0000_0000};
        tbl[1] = '{4, 0, 1, 1, {32'h0, 32'h0, 32'h0, 32'h807F01FE}, 4'b1111, 1'b0, 1'b0, 32'h00FF_FF00};
        tbl[2] = '{4, 1, 3, 2, {32'h0, 32'h0, 32'h8899AABB, 32'h11223344}, 4'b0011, 1'b0, 1'b0, 32'hFFFF_0000};
        tbl[3] = '{0, 2, 0, 2, {32'h0, 32'h0, 32'hAB00000F, 32'h12000F0F}, 4'b0000, 1'b1, 1'b0, 32'h0000_00FF};
        tbl[4] = '{7, 1, 1, 3, {32'h0, 32'h55AA55AA, 32'hF0E0D0C0, 32'h01020304}, 4'b1010, 1'b1, 1'b0, 32'hFF00_FF00};
        tbl[5] = '{2, 1, 1, 1, {32'h0, 32'h0, 32'h0, 32'h1234_8001}, 4'b0011, 1'b0, 1'b1, 32'h0000_00FF};
        tbl[6] = '{2, 5, 1, 1, {32'h0, 32'h0, 32'h0, 32'h5678_7F80}, 4'b0011, 1'b0, 1'b0, 32'h0000_FF00};

        rst_n = 1'b0; start_rqst = 1'b0; fin_rqst = 1'b0; inp_data = '0; inp_last_mask = '0;
        cfg_lanes = '0; cfg_go_cycles = '0; cfg_trail_cycles = '0;
        for (int k = 0; k < 4; k++) mtrail[k] = 8'h00;
        repeat (2) @(posedge clk_sys);
        #1 chk("reset", 0, outs(), 64'h0);
        @(negedge clk_sys) rst_n = 1'b1;
        @(posedge clk_sys); #1;
        chk("idle", 0, outs(), 64'h0);

        chained = 1'b0;
        for (int i = 0; i < 7; i++) begin
            words = tbl[i].w;
            run_burst(tbl[i].lanes, tbl[i].go, tbl[i].tr, tbl[i].nw, tbl[i].mask, tbl[i].spur,
                      chained, tbl[i].hold,
                      (i < 6) ? tbl[(i < 6) ? i + 1 : i].lanes : 0,
                      (i < 6) ? tbl[(i < 6) ? i + 1 : i].go : 0,
                      (i < 6) ? tbl[(i < 6) ? i + 1 : i].tr : 0, tseen, rq);
            chk("trail", i, 64'(tseen), 64'(tbl[i].exp_trail));
            chk("rqcnt", i, 64'(rq), 64'(tbl[i].nw));
            chained = tbl[i].hold;
        end

        for (int r = 0; r < 12; r++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) words[k] = $urandom;
            run_burst($urandom_range(7), $urandom_range(6), $urandom_range(5), nw,
                      4'($urandom_range(15)), bit'($urandom_range(1)), 1'b0, 1'b0, 0, 0, 0, tseen, rq);
            chk("rnd_rq", r, 64'(rq), 64'(nw));
        end

        // Reset in the middle of ACTIVE.
        cfg_lanes = 3'd4; cfg_go_cycles = 8'd0; cfg_trail_cycles = 8'd2;
        inp_data = 32'h5A5A_5A5A; start_rqst = 1'b1;
        @(posedge clk_sys); #1 start_rqst = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1 chk("pre_rst", 0, outs(), frame(1'b1, 1'b1, 1'b0, 4'hF, 32'h5A5A_5A5A));
        #2 rst_n = 1'b0;
        #1 chk("async_rst", 0, outs(), 64'h0);
        @(negedge clk_sys) rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_sys); #1;
            chk("post_rst", c, outs(), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
